// File: rtl/readout_rx_pkg.sv
// Shared definitions for the readout RX trial sequencer: FSM state encoding,
// bin-count zero point and a saturating up/down step helper.
package readout_rx_pkg;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_ACCUM  = 2'd1,
        RX_DECIDE = 2'd2
    } rx_state_e;

    // Offset-binary zero point 2^(width-1); callers cast down to their width.
    function automatic logic [31:0] bin_zero_point(input int unsigned width);
        return 32'd1 << (width - 32'd1);
    endfunction

    // One saturating step within [0, max_value]; simultaneous up and down cancel.
    function automatic logic [31:0] sat_step(
        input logic [31:0] value,
        input logic [31:0] max_value,
        input logic        up,
        input logic        down
    );
        logic [31:0] result;
        result = value;
        if (up && !down) begin
            if (value < max_value) begin
                result = value + 32'd1;
            end else begin
                result = value;
            end
        end else if (down && !up) begin
            if (value != 32'd0) begin
                result = value - 32'd1;
            end else begin
                result = value;
            end
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/readout_rx_sat_updown_counter.sv
// Width-parameterised saturating up/down counter with synchronous load.
// Load has priority over counting; the count never wraps.
module readout_rx_sat_updown_counter #(
    parameter int unsigned       WIDTH       = 16,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_in,
    input  logic [WIDTH-1:0] load_value_in,
    input  logic             inc_in,
    input  logic             dec_in,
    output logic [WIDTH-1:0] count_out
);
    import readout_rx_pkg::*;

    localparam logic [31:0] MAX_VALUE = 32'((64'd1 << WIDTH) - 64'd1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: load, else one saturating step.
    always_comb begin
        count_d = count_q;
        if (load_in) begin
            count_d = load_value_in;
        end else begin
            count_d = WIDTH'(sat_step(32'(count_q), MAX_VALUE, inc_in, dec_in));
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= RESET_VALUE;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_out = count_q;

endmodule

// File: rtl/readout_rx_trial_sequencer.sv
// Splits a discriminator sample stream into trials, keeps the cumulative
// offset-binary bin count and hands each trial boundary to the decision logic.
module readout_rx_trial_sequencer #(
    parameter int unsigned BIN_COUNTER_WIDTH           = 16,
    parameter int unsigned SAMPLE_COUNT_WIDTH          = 8,
    parameter int unsigned THRESHOLD_MEMORY_ADDR_WIDTH = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start_in,
    input  logic [SAMPLE_COUNT_WIDTH-1:0]          num_samples_in,
    input  logic [THRESHOLD_MEMORY_ADDR_WIDTH-1:0] num_trials_in,
    input  logic                                   sample_valid_in,
    input  logic                                   sample_state_in,
    input  logic                                   decision_fin_in,
    output logic [BIN_COUNTER_WIDTH-1:0]           bin_count_out,
    output logic                                   finish_trial_out,
    output logic                                   last_trial_out,
    output logic [THRESHOLD_MEMORY_ADDR_WIDTH-1:0] threshold_addr_out,
    output logic                                   busy_out,
    output logic [THRESHOLD_MEMORY_ADDR_WIDTH-1:0] trials_used_out
);
    import readout_rx_pkg::*;

    localparam int unsigned SW = SAMPLE_COUNT_WIDTH;
    localparam int unsigned TW = THRESHOLD_MEMORY_ADDR_WIDTH;
    localparam logic [BIN_COUNTER_WIDTH-1:0] ZERO_POINT =
        BIN_COUNTER_WIDTH'(bin_zero_point(BIN_COUNTER_WIDTH));

    rx_state_e         state_q,       state_d;
    logic [SW-1:0]     num_samples_q, num_samples_d;
    logic [TW-1:0]     num_trials_q,  num_trials_d;
    logic [TW-1:0]     trial_idx_q,   trial_idx_d;
    logic [SW-1:0]     sample_cnt_q,  sample_cnt_d;
    logic [TW-1:0]     trials_used_q, trials_used_d;
    logic              finish_q,      finish_d;
    logic              last_q,        last_d;
    logic              busy_q,        busy_d;

    logic              bin_load_s;
    logic              bin_inc_s;
    logic              bin_dec_s;
    logic              sample_done_s;
    logic              is_last_s;
    logic [SW-1:0]     num_samples_eff_s;
    logic [BIN_COUNTER_WIDTH-1:0] bin_count_s;

    assign sample_done_s     = ((sample_cnt_q + SW'(1)) == num_samples_q);
    assign is_last_s         = (trial_idx_q == num_trials_q);
    assign num_samples_eff_s = (num_samples_in == '0) ? SW'(1) : num_samples_in;

    // Next-state and counter control for the IDLE/ACCUM/DECIDE sequencer.
    always_comb begin
        state_d       = state_q;
        num_samples_d = num_samples_q;
        num_trials_d  = num_trials_q;
        trial_idx_d   = trial_idx_q;
        sample_cnt_d  = sample_cnt_q;
        trials_used_d = trials_used_q;
        bin_load_s    = 1'b0;
        bin_inc_s     = 1'b0;
        bin_dec_s     = 1'b0;

        case (state_q)
            RX_IDLE: begin
                if (start_in) begin
                    num_samples_d = num_samples_eff_s;
                    num_trials_d  = num_trials_in;
                    trial_idx_d   = '0;
                    sample_cnt_d  = '0;
                    bin_load_s    = 1'b1;
                    state_d       = RX_ACCUM;
                end else begin
                    state_d = RX_IDLE;
                end
            end
            RX_ACCUM: begin
                if (sample_valid_in) begin
                    bin_inc_s = sample_state_in;
                    bin_dec_s = !sample_state_in;
                    if (sample_done_s) begin
                        sample_cnt_d = '0;
                        state_d      = RX_DECIDE;
                    end else begin
                        sample_cnt_d = sample_cnt_q + SW'(1);
                    end
                end else begin
                    state_d = RX_ACCUM;
                end
            end
            RX_DECIDE: begin
                // A missing decision on the final trial still ends the run.
                if (decision_fin_in || is_last_s) begin
                    trials_used_d = trial_idx_q;
                    state_d       = RX_IDLE;
                end else begin
                    trial_idx_d = trial_idx_q + TW'(1);
                    if (sample_valid_in) begin
                        bin_inc_s = sample_state_in;
                        bin_dec_s = !sample_state_in;
                        // This sample is sample 1 of the next trial.
                        if (num_samples_q == SW'(1)) begin
                            sample_cnt_d = '0;
                            state_d      = RX_DECIDE;
                        end else begin
                            sample_cnt_d = SW'(1);
                            state_d      = RX_ACCUM;
                        end
                    end else begin
                        sample_cnt_d = '0;
                        state_d      = RX_ACCUM;
                    end
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase

        finish_d = (state_d == RX_DECIDE);
        last_d   = finish_d && (trial_idx_d == num_trials_d);
        busy_d   = (state_d != RX_IDLE);
    end

    // Sequencer state and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RX_IDLE;
            num_samples_q <= SW'(1);
            num_trials_q  <= '0;
            trial_idx_q   <= '0;
            sample_cnt_q  <= '0;
            trials_used_q <= '0;
            finish_q      <= 1'b0;
            last_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            num_samples_q <= num_samples_d;
            num_trials_q  <= num_trials_d;
            trial_idx_q   <= trial_idx_d;
            sample_cnt_q  <= sample_cnt_d;
            trials_used_q <= trials_used_d;
            finish_q      <= finish_d;
            last_q        <= last_d;
            busy_q        <= busy_d;
        end
    end

    readout_rx_sat_updown_counter #(
        .WIDTH       (BIN_COUNTER_WIDTH),
        .RESET_VALUE (ZERO_POINT)
    ) u_bin_counter (
        .clk           (clk),
        .rst           (rst),
        .load_in       (bin_load_s),
        .load_value_in (ZERO_POINT),
        .inc_in        (bin_inc_s),
        .dec_in        (bin_dec_s),
        .count_out     (bin_count_s)
    );

    assign bin_count_out      = bin_count_s;
    assign finish_trial_out   = finish_q;
    assign last_trial_out     = last_q;
    assign threshold_addr_out = trial_idx_q;
    assign busy_out           = busy_q;
    assign trials_used_out    = trials_used_q;

endmodule

// File: tb/tb_readout_rx_trial_sequencer.sv
// Scoreboard bench: a 16-bit and a 4-bit sequencer driven by directed vectors;
// expected trial boundaries are queued and checked by a monitor on negedge.
module tb_readout_rx_trial_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       sel4;
    logic       valid;
    logic       sstate;
    logic       fin_all16;
    logic       fin_all4;
    logic [7:0] nsamp;
    logic [3:0] ntri;

    logic [15:0] bin16;
    logic        fin16, last16, busy16, dfin16;
    logic [3:0]  addr16, used16;
    logic [3:0]  bin4;
    logic        fin4, last4, busy4, dfin4;
    logic [3:0]  addr4, used4;

    typedef struct packed {
        logic [15:0] bin;
        logic [3:0]  addr;
        logic        last;
    } exp_t;

    exp_t q16[$];
    exp_t q4[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    // Decision logic stand-in: either finish at once or only on the last trial.
    assign dfin16 = fin16 && (fin_all16 || last16);
    assign dfin4  = fin4  && (fin_all4  || last4);

    readout_rx_trial_sequencer #(
        .BIN_COUNTER_WIDTH(16), .SAMPLE_COUNT_WIDTH(8), .THRESHOLD_MEMORY_ADDR_WIDTH(4)
    ) dut16 (
        .clk(clk), .rst(rst), .start_in(start && !sel4), .num_samples_in(nsamp),
        .num_trials_in(ntri), .sample_valid_in(valid), .sample_state_in(sstate),
        .decision_fin_in(dfin16), .bin_count_out(bin16), .finish_trial_out(fin16),
        .last_trial_out(last16), .threshold_addr_out(addr16), .busy_out(busy16),
        .trials_used_out(used16)
    );

    readout_rx_trial_sequencer #(
        .BIN_COUNTER_WIDTH(4), .SAMPLE_COUNT_WIDTH(8), .THRESHOLD_MEMORY_ADDR_WIDTH(4)
    ) dut4 (
        .clk(clk), .rst(rst), .start_in(start && sel4), .num_samples_in(nsamp),
        .num_trials_in(ntri), .sample_valid_in(valid), .sample_state_in(sstate),
        .decision_fin_in(dfin4), .bin_count_out(bin4), .finish_trial_out(fin4),
        .last_trial_out(last4), .threshold_addr_out(addr4), .busy_out(busy4),
        .trials_used_out(used4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] ns, input logic [3:0] nt, input logic to4);
        sel4  = to4;
        nsamp = ns;
        ntri  = nt;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic b);
        valid  = 1'b1;
        sstate = b;
        tick();
        valid  = 1'b0;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (fin16) begin
                if (q16.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL finish16_unexpected: got pulse bin=0x%0h addr=%0d, expected none", bin16, addr16);
                end else begin
                    e = q16.pop_front();
                    chk("finish16_bin",  32'(bin16),  32'(e.bin));
                    chk("finish16_addr", 32'(addr16), 32'(e.addr));
                    chk("finish16_last", 32'(last16), 32'(e.last));
                end
            end else if (last16) begin
                n_tests++;
                n_fail++;
                $display("FAIL last16_without_finish: got 1 expected 0");
            end
            if (fin4) begin
                if (q4.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL finish4_unexpected: got pulse bin=0x%0h, expected none", bin4);
                end else begin
                    e = q4.pop_front();
                    chk("finish4_bin",  32'(bin4),  32'(e.bin[3:0]));
                    chk("finish4_addr", 32'(addr4), 32'(e.addr));
                    chk("finish4_last", 32'(last4), 32'(e.last));
                end
            end else if (last4) begin
                n_tests++;
                n_fail++;
                $display("FAIL last4_without_finish: got 1 expected 0");
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sel4 = 1'b0; valid = 1'b0; sstate = 1'b0;
        fin_all16 = 1'b1; fin_all4 = 1'b1; nsamp = 8'd0; ntri = 4'd0;
        fork
            monitor();
        join_none
        tick();
        tick();
        chk("reset_bin16",  32'(bin16),  32'h8000);
        chk("reset_bin4",   32'(bin4),   32'h8);
        chk("reset_finish", 32'(fin16),  32'd0);
        chk("reset_addr",   32'(addr16), 32'd0);
        chk("reset_busy",   32'(busy16), 32'd0);
        chk("reset_used",   32'(used16), 32'd0);
        rst = 1'b0;
        tick();

        // 1: four |1> samples, immediate decision.
        fin_all16 = 1'b1;
        do_start(8'd4, 4'd2, 1'b0);
        chk("t1_busy_start", 32'(busy16), 32'd1);
        q16.push_back('{bin: 16'h8004, addr: 4'd0, last: 1'b0});
        for (int i = 0; i < 4; i++) send(1'b1);
        tick();
        chk("t1_busy_end", 32'(busy16), 32'd0);
        chk("t1_used",     32'(used16), 32'd0);
        chk("t1_bin_hold", 32'(bin16),  32'h8004);

        // 2: 1,0,1,0 per trial, decision only on the last trial.
        fin_all16 = 1'b0;
        do_start(8'd4, 4'd2, 1'b0);
        chk("t2_bin_reload", 32'(bin16), 32'h8000);
        for (int t = 0; t < 3; t++) begin
            q16.push_back('{bin: 16'h8000, addr: 4'(t), last: (t == 2)});
            send(1'b1); send(1'b0); send(1'b1); send(1'b0);
            tick();
        end
        chk("t2_used", 32'(used16), 32'd2);
        chk("t2_busy", 32'(busy16), 32'd0);

        // 3: 4-bit counter saturates high then low.
        fin_all4 = 1'b1;
        do_start(8'd10, 4'd0, 1'b1);
        q4.push_back('{bin: 16'h000F, addr: 4'd0, last: 1'b1});
        for (int i = 0; i < 10; i++) send(1'b1);
        tick();
        chk("t3_sat_high", 32'(bin4),  32'hF);
        chk("t3_busy",     32'(busy4), 32'd0);
        do_start(8'd10, 4'd0, 1'b1);
        chk("t3_reload", 32'(bin4), 32'h8);
        q4.push_back('{bin: 16'h0000, addr: 4'd0, last: 1'b1});
        for (int i = 0; i < 10; i++) send(1'b0);
        tick();
        chk("t3_sat_low", 32'(bin4),  32'h0);
        chk("t3_used",    32'(used4), 32'd0);
        sel4 = 1'b0;

        // 4: sample in DECIDE counts when continuing, dropped when finishing.
        fin_all16 = 1'b0;
        do_start(8'd3, 4'd1, 1'b0);
        q16.push_back('{bin: 16'h8003, addr: 4'd0, last: 1'b0});
        q16.push_back('{bin: 16'h8004, addr: 4'd1, last: 1'b1});
        send(1'b1); send(1'b1); send(1'b1); send(1'b1);
        send(1'b1); send(1'b0); send(1'b1);
        chk("t4_busy",    32'(busy16), 32'd0);
        chk("t4_dropped", 32'(bin16),  32'h8004);
        chk("t4_used",    32'(used16), 32'd1);

        // 5: start ignored while busy; rst aborts with no finish pulse.
        fin_all16 = 1'b1;
        do_start(8'd4, 4'd3, 1'b0);
        send(1'b1); send(1'b1);
        do_start(8'd1, 4'd0, 1'b0);
        send(1'b1);
        chk("t5_busy_mid", 32'(busy16), 32'd1);
        chk("t5_bin_mid",  32'(bin16),  32'h8003);
        rst = 1'b1; valid = 1'b1; sstate = 1'b1;
        tick();
        rst = 1'b0; valid = 1'b0;
        chk("t5_rst_busy",   32'(busy16), 32'd0);
        chk("t5_rst_bin",    32'(bin16),  32'h8000);
        chk("t5_rst_finish", 32'(fin16),  32'd0);
        chk("t5_rst_used",   32'(used16), 32'd0);
        send(1'b1);
        tick();
        chk("t5_idle_ignore", 32'(bin16), 32'h8000);

        // 6: num_samples = 0 behaves as one sample per trial.
        fin_all16 = 1'b0;
        do_start(8'd0, 4'd3, 1'b0);
        q16.push_back('{bin: 16'h8001, addr: 4'd0, last: 1'b0});
        q16.push_back('{bin: 16'h8000, addr: 4'd1, last: 1'b0});
        q16.push_back('{bin: 16'h8001, addr: 4'd2, last: 1'b0});
        q16.push_back('{bin: 16'h8002, addr: 4'd3, last: 1'b1});
        send(1'b1); tick();
        send(1'b0); tick();
        send(1'b1); tick();
        send(1'b1); tick();
        chk("t6_used", 32'(used16), 32'd3);
        chk("t6_busy", 32'(busy16), 32'd0);

        tick();
        tick();
        chk("pending16", 32'(q16.size()), 32'd0);
        chk("pending4",  32'(q4.size()),  32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/readout_rx_trial_sequencer.md
Name: readout_rx_trial_sequencer

Overview:
- Upstream driver for the readout RX state-decision output logic.
- Consumes the per-sample discriminator stream (1 bit per sample: |1> or |0>). Keeps a cumulative offset-binary bin count of samples(|1>) - samples(|0>).
- Splits the measurement into trials. At each trial boundary it presents bin count, finish_trial, last_trial and threshold address to the decision logic, then ends or continues on the returned decision_fin.

Parameters:
- BIN_COUNTER_WIDTH, 16, bin count width; zero point is 2^(BIN_COUNTER_WIDTH-1).
- SAMPLE_COUNT_WIDTH, 8, width of the samples-per-trial counter.
- THRESHOLD_MEMORY_ADDR_WIDTH, 4, trial index width; max trials = 2^THRESHOLD_MEMORY_ADDR_WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start_in  in  1  measurement request pulse; honoured only in IDLE
- num_samples_in  in  SAMPLE_COUNT_WIDTH  samples per trial, latched on accepted start
- num_trials_in  in  THRESHOLD_MEMORY_ADDR_WIDTH  index of last trial, latched on accepted start
- sample_valid_in  in  1  discriminator sample strobe
- sample_state_in  in  1  1 = |1>, 0 = |0>
- decision_fin_in  in  1  combinational return from decision logic, same cycle as finish_trial_out
- bin_count_out  out  BIN_COUNTER_WIDTH  registered cumulative bin count
- finish_trial_out  out  1  trial-boundary pulse
- last_trial_out  out  1  high with finish_trial_out on the final trial
- threshold_addr_out  out  THRESHOLD_MEMORY_ADDR_WIDTH  current trial index
- busy_out  out  1  high in ACCUM or DECIDE
- trials_used_out  out  THRESHOLD_MEMORY_ADDR_WIDTH  trial index at which the last measurement ended

Behaviour:
- Reset: state IDLE. bin_count_out = 2^(W-1). All other outputs 0.
- FSM states: IDLE, ACCUM, DECIDE.
- IDLE:
  - start_in = 1 latches the configuration, sets bin_count_out to 2^(W-1), trial index 0, sample counter 0, then goes to ACCUM.
  - num_samples_in = 0 is treated as 1.
  - Samples arriving in IDLE are ignored.
- ACCUM, on each sample_valid_in:
  - bin count +1 if sample_state_in = 1, else -1.
  - Saturating: holds at 0 and at all-ones, never wraps.
  - Sample counter +1. On the sample that reaches num_samples, go to DECIDE next cycle with sample counter cleared.
- DECIDE (exactly one cycle):
  - finish_trial_out = 1 and last_trial_out = (trial index == latched num_trials).
  - bin_count_out and threshold_addr_out are stable this cycle, which gives zero-latency combinational closure with the decision logic.
  - If decision_fin_in = 1: trials_used_out <= trial index, then IDLE.
  - Otherwise: trial index +1, then ACCUM.
  - When last_trial_out = 1, decision_fin_in is required to be 1. If it is 0, still go to IDLE (no wrap of the trial index).
- Sample valid during DECIDE:
  - If continuing: applied to the bin counter and counted as sample 1 of the next trial.
  - If finishing: discarded.
- finish_trial_out and last_trial_out are single-cycle pulses. They are never asserted outside DECIDE.
- start_in while busy is ignored; no restart mid-measurement.
- rst mid-measurement aborts immediately to reset values, with no finish pulse. A finish pulse coincident with rst is suppressed.
- bin_count_out holds its final value in IDLE until the next accepted start.

Decomposition:
- Shared package readout_rx_pkg holds:
  - state encoding (IDLE/ACCUM/DECIDE),
  - function returning the bin-count zero point 2^(W-1),
  - saturating up/down helper.
- One natural sub-module: readout_rx_sat_updown_counter (width-parameterised, load / inc / dec, saturating). It is reusable by the decision-side diagnostics.

Test Plan:
1. Reset, then start with num_samples = 4, num_trials = 2; feed 4 samples of 1; tie decision_fin_in = 1 -> finish_trial_out pulse with bin_count_out = 0x8004, threshold_addr_out = 0, last_trial_out = 0; busy_out drops next cycle; trials_used_out = 0.
2. Same config, samples 1,0,1,0 per trial; decision_fin_in = 0 until last -> finish pulses at addr 0, 1, 2, with last_trial_out = 1 only at addr 2; bin_count_out = 0x8000 each time; trials_used_out = 2.
3. W = 4, num_samples = 10, all samples 1 -> bin_count_out saturates at 0xF, no wrap. All samples 0 -> saturates at 0x0.
4. Sample_valid asserted in the DECIDE cycle with continuation -> next trial finishes after num_samples - 1 further samples and includes that sample. With decision_fin_in = 1 the sample is dropped and bin_count_out is unchanged.
5. start_in during ACCUM ignored; rst asserted mid-ACCUM -> next cycle IDLE, bin_count_out = 0x8000, no finish_trial_out pulse.
6. num_samples_in = 0 -> a trial ends after every single sample.
